// File: rtl/fir_mem_arbiter_pkg.sv
// Shared definitions for the FIR memory arbiter: memory geometry, requester
// indices, arbiter state encoding and the round-robin index helper.
package fir_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    localparam int REQ_AXI_WR = 0;
    localparam int REQ_AXI_RD = 1;
    localparam int REQ_FIR    = 2;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    // Position k of a wrapping search that starts at base over n requesters
    function automatic int rr_idx(input int base, input int k, input int n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/fir_mem_arbiter_if.sv
// Requester-side bus of the FIR memory arbiter. Lanes are packed, requester i
// at [i*W +: W]. master = requester side, slave = arbiter side.
interface fir_mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = fir_pkg::ADDR_W,
    parameter int DATA_W = fir_pkg::DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/fir_mem_arbiter_rr_pick.sv
// fir_rr_pick: combinational round-robin winner selection. The search starts
// at rr_ptr and wraps; with prio_en the FIR engine wins whenever it requests.
module fir_rr_pick
    import fir_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             prio_en,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);

    logic found;

    // First set request at or after rr_ptr wins; prioritised FIR overrides it
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[IDX_W'(rr_idx(int'(rr_ptr), k, N_REQ))]) begin
                found   = 1'b1;
                win_idx = IDX_W'(rr_idx(int'(rr_ptr), k, N_REQ));
            end
        end
        if (prio_en && req[IDX_W'(REQ_FIR)]) begin
            found   = 1'b1;
            win_idx = IDX_W'(REQ_FIR);
        end
        if (found) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mem_arbiter.sv
// fir_mem_arbiter: shares the single-port FIR sample/coefficient memory
// between AXI write, AXI read and the FIR engine. Round-robin with burst
// locking, bounded to MAX_BURST accesses per grant, one ARB bubble between
// owners. Read valids ride a registered one-hot pipeline so they survive
// ownership changes.
// Build option: FIR_ARB_PRIO_EN -- FIR engine always wins and is not capped.
module fir_mem_arbiter
    import fir_pkg::*;
#(
    parameter int ADDR_W    = fir_pkg::ADDR_W,
    parameter int DATA_W    = fir_pkg::DATA_W,
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 16
) (
    input  logic              a_clk,
    input  logic              a_rst_n,
    fir_mem_arbiter_if.slave  bus,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef FIR_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic [N_REQ-1:0]  win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              own_req, own_lock, own_we, cap_en;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    fir_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .prio_en (PRIO_EN),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    // The prioritised FIR engine is exempt from the burst cap
    assign cap_en = !(PRIO_EN && (owner_q == IDX_W'(REQ_FIR)));

    // Select the current owner's lane of the request bus
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_req   = bus.req[i];
                own_lock  = bus.lock[i];
                own_we    = bus.we[i];
                own_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                own_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: grant in ARB, count accesses and decide release in OWN
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        rvalid_d    = '0;
        if (state_q == ARB) begin
            if (|win_oh) begin
                state_d     = OWN;
                owner_d     = win_idx;
                burst_cnt_d = '0;
                rr_ptr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end
        end else begin
            if (!own_req) begin
                state_d = ARB;
            end else begin
                if (burst_cnt_q != CNT_W'(MAX_BURST)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (!own_we) begin
                    rvalid_d[owner_q] = 1'b1;
                end
                if (!own_lock || (cap_en && (burst_cnt_q == CNT_W'(MAX_BURST - 1)))) begin
                    state_d = ARB;
                end
            end
        end
    end

    // Drive grant and memory port from the owner while in OWN
    always_comb begin
        bus.gnt   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == OWN) begin
            bus.gnt[owner_q] = 1'b1;
            mem_en           = own_req;
            mem_we           = own_req & own_we;
            mem_addr         = own_addr;
            mem_wdata        = own_wdata;
        end
    end

    // Arbiter state; reset drops any read return still in flight
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = mem_rdata;

endmodule

// File: tb/tb_fir_mem_arbiter.sv
// Self-checking bench for fir_mem_arbiter: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_fir_mem_arbiter;
    import fir_pkg::*;

    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int NR   = 3;
    localparam int MAXB = 16;

`ifdef FIR_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          a_clk = 1'b0;
    logic          a_rst_n;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    fir_mem_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    fir_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .N_REQ(NR), .MAX_BURST(MAXB)
    ) dut (
        .a_clk     (a_clk),
        .a_rst_n   (a_rst_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 a_clk = ~a_clk;

    // Memory macro stand-in: registered read, unwritten words have fixed content
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    bit            wr_flag [0:(1<<AW)-1];

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a == 13'h00B) ? 16'h1234 : {3'b101, a};
    endfunction

    always @(posedge a_clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr] ? mem[mem_addr] : dflt(mem_addr);
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    bit            m_own;
    int            m_owner, m_rr, m_cnt, m_rv;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] m_mem [int];

    function automatic bit bitof(input logic [NR-1:0] v, input int i);
        return v[i[1:0]];
    endfunction

    function automatic logic [AW-1:0] get_addr(input int i);
        return AW'(bus.addr >> (i*AW));
    endfunction

    function automatic logic [DW-1:0] get_wdata(input int i);
        return DW'(bus.wdata >> (i*DW));
    endfunction

    function automatic int model_pick(input logic [NR-1:0] r);
        if (PRIO && bitof(r, REQ_FIR)) return REQ_FIR;
        for (int k = 0; k < NR; k++) begin
            if (bitof(r, (m_rr + k) % NR)) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = 1'b0; m_owner = 0; m_rr = 0; m_cnt = 0; m_rv = -1;
    endtask

    // One clock edge worth of arbiter behaviour, from the rules
    task automatic model_step();
        int w;
        logic [AW-1:0] a;
        bit capped;
        if (!a_rst_n) begin
            model_reset();
            return;
        end
        m_rv = -1;
        if (!m_own) begin
            w = model_pick(bus.req);
            if (w >= 0) begin
                m_own = 1'b1; m_owner = w; m_cnt = 0; m_rr = (w + 1) % NR;
            end
        end else if (!bitof(bus.req, m_owner)) begin
            m_own = 1'b0;
        end else begin
            a = get_addr(m_owner);
            m_cnt++;
            if (bitof(bus.we, m_owner)) begin
                m_mem[int'(a)] = get_wdata(m_owner);
            end else begin
                m_rv      = m_owner;
                m_rv_data = m_mem.exists(int'(a)) ? m_mem[int'(a)] : dflt(a);
            end
            capped = !(PRIO && m_owner == REQ_FIR) && (m_cnt == MAXB);
            if (!bitof(bus.lock, m_owner) || capped) m_own = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [NR-1:0] eg, erv;
        logic ee, ew;
        eg  = m_own ? NR'(1 << m_owner) : '0;
        ee  = m_own && bitof(bus.req, m_owner);
        ew  = ee && bitof(bus.we, m_owner);
        erv = (m_rv >= 0) ? NR'(1 << m_rv) : '0;
        chk("gnt",    32'(bus.gnt),    32'(eg));
        chk("mem_en", 32'(mem_en),     32'(ee));
        chk("mem_we", 32'(mem_we),     32'(ew));
        chk("rvalid", 32'(bus.rvalid), 32'(erv));
        if (ee)      chk("mem_addr",  32'(mem_addr),  32'(get_addr(m_owner)));
        if (ew)      chk("mem_wdata", 32'(mem_wdata), 32'(get_wdata(m_owner)));
        if (m_rv >= 0) chk("rdata",   32'(bus.rdata), 32'(m_rv_data));
    endtask

    task automatic sample();
        @(negedge a_clk);
        if (!a_rst_n) model_reset();
        check_model();
    endtask

    task automatic advance();
        @(posedge a_clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        a_rst_n = 1'b0;
        cycle();
        a_rst_n = 1'b1;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    logic [NR-1:0] first_g;
    logic [NR-1:0] rr_exp [0:7];
    int exp_cnt2, exp_g0, cnt2, first_g0;

    initial begin
        if (PRIO) begin
            first_g  = 3'b100;
            rr_exp   = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b100};
            exp_cnt2 = 40;
            exp_g0   = -1;
        end else begin
            first_g  = 3'b001;
            rr_exp   = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
            exp_cnt2 = MAXB;
            exp_g0   = MAXB + 1;
        end
        model_reset();

        // Reset with every requester asking
        a_rst_n   = 1'b0;
        bus.req   = 3'b111;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        sample();
        chk("rst_gnt",       32'(bus.gnt),    32'h0);
        chk("rst_rvalid",    32'(bus.rvalid), 32'h0);
        chk("rst_mem_en",    32'(mem_en),     32'h0);
        chk("rst_mem_we",    32'(mem_we),     32'h0);
        chk("rst_mem_addr",  32'(mem_addr),   32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata),  32'h0);
        advance();
        cycle();
        a_rst_n = 1'b1;
        sample();
        chk("rst_arb_gnt", 32'(bus.gnt), 32'h0);
        advance();
        sample();
        chk("rst_first_gnt", 32'(bus.gnt), 32'(first_g));
        advance();
        bus.req = '0;
        cycle();
        cycle();

        // Single write from the AXI write path
        bus.req = 3'b001; bus.we = 3'b001; bus.lock = '0;
        set_lane(REQ_AXI_WR, 13'h00A, 16'hABCD);
        cycle();
        sample();
        chk("wr_gnt",   32'(bus.gnt),   32'h1);
        chk("wr_en",    32'(mem_en),    32'h1);
        chk("wr_we",    32'(mem_we),    32'h1);
        chk("wr_addr",  32'(mem_addr),  32'h00A);
        chk("wr_wdata", 32'(mem_wdata), 32'hABCD);
        advance();
        bus.req = '0;
        sample();
        chk("wr_release", 32'(bus.gnt), 32'h0);
        chk("wr_idle_en", 32'(mem_en),  32'h0);
        chk("wr_mem",     32'(mem[13'h00A]), 32'hABCD);
        advance();

        // Read return to the AXI read path
        bus.req = 3'b010; bus.we = '0;
        set_lane(REQ_AXI_RD, 13'h00B, 16'h0);
        cycle();
        sample();
        chk("rd_gnt",  32'(bus.gnt),  32'h2);
        chk("rd_en",   32'(mem_en),   32'h1);
        chk("rd_we",   32'(mem_we),   32'h0);
        chk("rd_addr", 32'(mem_addr), 32'h00B);
        advance();
        bus.req = '0;
        sample();
        chk("rd_rvalid", 32'(bus.rvalid), 32'h2);
        chk("rd_rdata",  32'(bus.rdata),  32'h1234);
        advance();

        // Round-robin rotation with one ARB bubble between owners
        do_reset();
        bus.req = 3'b111; bus.lock = '0; bus.we = '0;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk($sformatf("rr_%0d", k), 32'(bus.gnt), 32'(rr_exp[k]));
            advance();
        end

        // Burst cap on a locked FIR engine with AXI write waiting
        do_reset();
        bus.req = 3'b100; bus.lock = 3'b100; bus.we = 3'b100;
        set_lane(REQ_FIR, 13'h020, 16'h5A5A);
        cycle();
        bus.req  = 3'b101;
        cnt2     = 0;
        first_g0 = -1;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (bus.gnt == 3'b001 && first_g0 < 0) first_g0 = k;
            if (bus.gnt == 3'b100 && mem_en && first_g0 < 0) cnt2++;
            advance();
        end
        chk("burst_cnt", 32'(cnt2),     32'(exp_cnt2));
        chk("burst_g0",  32'(first_g0), 32'(exp_g0));

        // Reset in the middle of a locked read burst
        do_reset();
        bus.req = 3'b001; bus.lock = 3'b001; bus.we = '0;
        set_lane(REQ_AXI_WR, 13'h00B, 16'h0);
        cycle();
        cycle();
        sample();
        chk("mid_rv_pre", 32'(bus.rvalid), 32'h1);
        advance();
        a_rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_gnt",    32'(bus.gnt),    32'h0);
        chk("mid_rvalid", 32'(bus.rvalid), 32'h0);
        chk("mid_mem_en", 32'(mem_en),     32'h0);
        cycle();
        a_rst_n  = 1'b1;
        bus.req  = 3'b111;
        bus.lock = '0;
        sample();
        chk("mid_post_arb", 32'(bus.gnt), 32'h0);
        advance();
        sample();
        chk("mid_post_gnt", 32'(bus.gnt), 32'(first_g));
        advance();

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 400; n++) begin
            a_rst_n  = ($urandom_range(0, 63) != 0);
            bus.req  = NR'($urandom);
            bus.lock = NR'($urandom);
            bus.we   = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                set_lane(i, AW'($urandom_range(0, 15)), DW'($urandom));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
